// File: rtl/l2_pkg.sv
// Shared types and helpers for the L2 way write-port sequencer.
package l2_pkg;

  localparam int L2_INDEX_W  = 10;
  localparam int L2_TAG_W    = 16;
  localparam int L2_ADDR_W   = L2_TAG_W + L2_INDEX_W;
  localparam int L2_MAX_WAYS = 4;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    TSCHK,
    TSWAIT,
    FILL
  } l2_state_e;

  // Isolates the lowest set bit so multiple tag matches pick one way.
  function automatic logic [L2_MAX_WAYS-1:0] lowest_set(input logic [L2_MAX_WAYS-1:0] v);
    return v & (~v + {{(L2_MAX_WAYS-1){1'b0}}, 1'b1});
  endfunction

  function automatic logic [L2_MAX_WAYS-1:0] onehot(input logic [1:0] idx);
    return {{(L2_MAX_WAYS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/l2_victim_ptr.sv
// Round-robin replacement pointer over WAYS ways; advances by one on i_adv.
module l2_victim_ptr #(
  parameter int WAYS = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_adv,
  output logic [1:0] o_ptr
);

  localparam logic [1:0] LAST = 2'(WAYS - 1);

  logic [1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= 2'd0;
    end else if (i_adv) begin
      r_ptr <= (r_ptr == LAST) ? 2'd0 : r_ptr + 2'd1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/l2_cache_ctrl.sv
// Write/tag-snoop port sequencer for the L2 ways: flush sweep > CPU write-through > memory fill.
// Optional L2_WRALLOC_EN: full-mask CPU write misses allocate into the victim way.
module l2_cache_ctrl
  import l2_pkg::*;
#(
  parameter int WAYS        = 2,
  parameter int INDEX_W     = L2_INDEX_W,
  parameter int SWEEP_START = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flushreq,
  output logic                 o_busy,
  input  logic                 i_cpuwrreq,
  input  logic [L2_ADDR_W-1:0] i_cpuwra,
  input  logic [31:0]          i_cpuwrd,
  input  logic [3:0]           i_cpuwrm,
  output logic                 o_cpuwrack,
  input  logic                 i_fillreq,
  input  logic [L2_ADDR_W-1:0] i_filla,
  input  logic [31:0]          i_filld,
  output logic                 o_fillack,
  input  logic [WAYS-1:0]      i_tsmatch,
  output logic [L2_ADDR_W-1:0] o_wra,
  output logic [31:0]          o_wrd,
  output logic [3:0]           o_wrm,
  output logic                 o_ts,
  output logic [WAYS-1:0]      o_wr,
  output logic                 o_clr,
  output logic                 o_all
);

  localparam logic [INDEX_W-1:0] IDX_LAST = '1;

  l2_state_e            r_state;
  logic [INDEX_W-1:0]   r_idx;
  logic                 r_flush_pend;
  logic                 r_fill_stale;
  logic                 r_busy;
  logic [L2_ADDR_W-1:0] r_wra;
  logic [31:0]          r_wrd;
  logic [3:0]           r_wrm;
  logic                 r_ts;
  logic [WAYS-1:0]      r_wr;
  logic                 r_clr;
  logic                 r_all;
  logic                 r_cpuwrack;
  logic                 r_fillack;

  l2_state_e            w_next_state;
  logic [INDEX_W-1:0]   w_idx_next;
  logic [INDEX_W-1:0]   w_idx_eff;
  logic                 w_flush_req;
  logic                 w_flush_pend_next;
  logic                 w_fill_stale_next;
  logic                 w_victim_adv;
  logic [1:0]           w_victim;
  logic [L2_MAX_WAYS-1:0] w_ts4;
  logic [L2_MAX_WAYS-1:0] w_wr4;
  logic [L2_ADDR_W-1:0] w_wra;
  logic [31:0]          w_wrd;
  logic [3:0]           w_wrm;
  logic                 w_ts;
  logic                 w_clr;
  logic                 w_all;
  logic                 w_cpuwrack;
  logic                 w_fillack;

  l2_victim_ptr #(
    .WAYS (WAYS)
  ) u_victim (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_adv (w_victim_adv),
    .o_ptr (w_victim)
  );

  always_comb begin
    w_next_state      = r_state;
    w_idx_next        = r_idx;
    w_idx_eff         = r_idx;
    w_fill_stale_next = r_fill_stale;
    w_victim_adv      = 1'b0;
    w_wra             = r_wra;
    w_wrd             = r_wrd;
    w_wrm             = r_wrm;
    w_ts              = 1'b0;
    w_wr4             = '0;
    w_clr             = 1'b0;
    w_all             = 1'b0;
    w_cpuwrack        = 1'b0;
    w_fillack         = 1'b0;
    w_flush_req       = i_flushreq | r_flush_pend;
    w_ts4             = '0;
    w_ts4[WAYS-1:0]   = i_tsmatch;

    case (r_state)
      IDLE: begin
        // Requesters need the ACK cycle to drop or refresh their request.
        if (!(r_cpuwrack || r_fillack)) begin
          if (w_flush_req) begin
            w_next_state = FLUSH;
            w_idx_next   = '0;
          end else if (i_cpuwrreq) begin
            w_next_state = TSCHK;
            w_ts         = 1'b1;
            w_wra        = i_cpuwra;
          end else if (i_fillreq) begin
            w_next_state = FILL;
          end
        end
      end

      FLUSH: begin
        w_idx_eff        = i_flushreq ? '0 : r_idx;
        w_wra            = '0;
        w_wra[INDEX_W-1:0] = w_idx_eff;
        w_wr4[WAYS-1:0]  = '1;
        w_clr            = 1'b1;
        w_all            = 1'b1;
        w_idx_next       = w_idx_eff + INDEX_W'(1);
        if (w_idx_eff == IDX_LAST) begin
          w_next_state = IDLE;
        end
      end

      TSCHK: begin
        w_next_state = TSWAIT;
      end

      TSWAIT: begin
        w_wra        = i_cpuwra;
        w_wrd        = i_cpuwrd;
        w_wrm        = i_cpuwrm;
        w_cpuwrack   = 1'b1;
        w_next_state = IDLE;
        if (|w_ts4) begin
          w_wr4 = lowest_set(w_ts4);
        end
`ifdef L2_WRALLOC_EN
        else if (i_cpuwrm == 4'hF) begin
          w_wr4        = onehot(w_victim);
          w_victim_adv = 1'b1;
        end
`endif
        // A fill already waiting for this line would overwrite newer CPU data.
        if (i_fillreq && (i_filla == i_cpuwra)) begin
          w_fill_stale_next = 1'b1;
        end
      end

      FILL: begin
        w_wra             = i_filla;
        w_wrd             = i_filld;
        w_wrm             = 4'hF;
        w_fillack         = 1'b1;
        w_fill_stale_next = 1'b0;
        w_next_state      = IDLE;
        if (!r_fill_stale) begin
          w_wr4        = onehot(w_victim);
          w_victim_adv = 1'b1;
        end
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase

    w_flush_pend_next = ((r_state == FLUSH) || (w_next_state == FLUSH)) ? 1'b0
                      : (r_flush_pend | i_flushreq);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= (SWEEP_START != 0) ? FLUSH : IDLE;
      r_busy       <= (SWEEP_START != 0);
      r_idx        <= '0;
      r_flush_pend <= 1'b0;
      r_fill_stale <= 1'b0;
      r_wra        <= '0;
      r_wrd        <= '0;
      r_wrm        <= '0;
      r_ts         <= 1'b0;
      r_wr         <= '0;
      r_clr        <= 1'b0;
      r_all        <= 1'b0;
      r_cpuwrack   <= 1'b0;
      r_fillack    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_busy       <= (w_next_state == FLUSH);
      r_idx        <= w_idx_next;
      r_flush_pend <= w_flush_pend_next;
      r_fill_stale <= w_fill_stale_next;
      r_wra        <= w_wra;
      r_wrd        <= w_wrd;
      r_wrm        <= w_wrm;
      r_ts         <= w_ts;
      r_wr         <= w_wr4[WAYS-1:0];
      r_clr        <= w_clr;
      r_all        <= w_all;
      r_cpuwrack   <= w_cpuwrack;
      r_fillack    <= w_fillack;
    end
  end

  assign o_busy     = r_busy;
  assign o_cpuwrack = r_cpuwrack;
  assign o_fillack  = r_fillack;
  assign o_wra      = r_wra;
  assign o_wrd      = r_wrd;
  assign o_wrm      = r_wrm;
  assign o_ts       = r_ts;
  assign o_wr       = r_wr;
  assign o_clr      = r_clr;
  assign o_all      = r_all;

endmodule

// File: tb/tb_l2_cache_ctrl.sv
// Scoreboard bench for l2_cache_ctrl: expected port events queued by stimulus, popped by a monitor.
module tb_l2_cache_ctrl;

  localparam int WAYS = 2;
  localparam int NIDX = 1024;
`ifdef L2_WRALLOC_EN
  localparam bit WRALLOC = 1'b1;
`else
  localparam bit WRALLOC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flushreq = 1'b0;
  logic        cpuwrreq = 1'b0;
  logic [25:0] cpuwra = '0;
  logic [31:0] cpuwrd = '0;
  logic [3:0]  cpuwrm = '0;
  logic        fillreq = 1'b0;
  logic [25:0] filla = '0;
  logic [31:0] filld = '0;
  logic [1:0]  tsmatch = '0;
  logic        o_busy, o_cpuwrack, o_fillack, o_ts, o_clr, o_all;
  logic [25:0] o_wra;
  logic [31:0] o_wrd;
  logic [3:0]  o_wrm;
  logic [1:0]  o_wr;

  always #5 clk = ~clk;

  l2_cache_ctrl #(.WAYS(WAYS), .INDEX_W(10), .SWEEP_START(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_flushreq(flushreq), .o_busy(o_busy),
    .i_cpuwrreq(cpuwrreq), .i_cpuwra(cpuwra), .i_cpuwrd(cpuwrd), .i_cpuwrm(cpuwrm),
    .o_cpuwrack(o_cpuwrack), .i_fillreq(fillreq), .i_filla(filla), .i_filld(filld),
    .o_fillack(o_fillack), .i_tsmatch(tsmatch), .o_wra(o_wra), .o_wrd(o_wrd),
    .o_wrm(o_wrm), .o_ts(o_ts), .o_wr(o_wr), .o_clr(o_clr), .o_all(o_all)
  );

  typedef struct {
    int          kind;  // 0 sweep write, 1 tag snoop, 2 cpu ack, 3 fill ack
    logic        ts, clr, all, cack, fack, chk_addr, chk_data;
    logic [1:0]  wr;
    logic [25:0] wra;
    logic [31:0] wrd;
    logic [3:0]  wrm;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   mon_en = 1'b0;
  bit   mon_ok;
  int   n_checks = 0;
  int   n_errs = 0;
  int   vptr = 0;

  function automatic exp_t blank_exp();
    exp_t e;
    e.kind = 0; e.ts = 0; e.clr = 0; e.all = 0; e.cack = 0; e.fack = 0;
    e.chk_addr = 0; e.chk_data = 0; e.wr = '0; e.wra = '0; e.wrd = '0; e.wrm = '0;
    return e;
  endfunction

  function automatic string kind_name(input int k);
    case (k)
      0: return "sweep_write";
      1: return "tag_snoop";
      2: return "cpu_ack";
      default: return "fill_ack";
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && (o_ts || o_wr != 2'b00 || o_clr || o_all || o_cpuwrack || o_fillack)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errs++;
        $display("FAIL unexpected_event: ts=%0b wr=%b clr=%0b all=%0b cack=%0b fack=%0b wra=%h, expected no event",
                 o_ts, o_wr, o_clr, o_all, o_cpuwrack, o_fillack, o_wra);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_ok = (o_ts == mon_e.ts) && (o_wr == mon_e.wr) && (o_clr == mon_e.clr) &&
                 (o_all == mon_e.all) && (o_cpuwrack == mon_e.cack) && (o_fillack == mon_e.fack) &&
                 (!mon_e.chk_addr || o_wra == mon_e.wra) &&
                 (!mon_e.chk_data || (o_wrd == mon_e.wrd && o_wrm == mon_e.wrm));
        if (!mon_ok) begin
          n_errs++;
          $display("FAIL %s: got ts=%0b wr=%b clr=%0b all=%0b cack=%0b fack=%0b wra=%h wrd=%h wrm=%h, expected ts=%0b wr=%b clr=%0b all=%0b cack=%0b fack=%0b wra=%h wrd=%h wrm=%h",
                   kind_name(mon_e.kind), o_ts, o_wr, o_clr, o_all, o_cpuwrack, o_fillack, o_wra, o_wrd, o_wrm,
                   mon_e.ts, mon_e.wr, mon_e.clr, mon_e.all, mon_e.cack, mon_e.fack, mon_e.wra, mon_e.wrd, mon_e.wrm);
        end
      end
    end
  end

  task automatic push_sweep(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = blank_exp();
      e.wr = 2'b11; e.clr = 1'b1; e.all = 1'b1; e.wra = 26'(i); e.chk_addr = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  // Pushes the fill outcome: dropped when stale, otherwise written to the round-robin victim.
  task automatic push_fill(input bit stale, input logic [25:0] fa, input logic [31:0] fd);
    exp_t e;
    e = blank_exp();
    e.kind = 3; e.fack = 1'b1;
    if (!stale) begin
      e.wr = 2'(1 << vptr); e.wra = fa; e.wrd = fd; e.wrm = 4'hF;
      e.chk_addr = 1'b1; e.chk_data = 1'b1;
      vptr = (vptr + 1) % WAYS;
    end
    exp_q.push_back(e);
  endtask

  task automatic count_busy(input int req, input string nm);
    int cnt;
    bit done;
    cnt = 0;
    done = 1'b0;
    for (int c = 0; c < 3000 && !done; c++) begin
      if (o_busy) cnt++;
      else if (cnt > 0) done = 1'b1;
      if (!done) @(negedge clk);
    end
    chk(nm, cnt, req);
    @(negedge clk);
    chk({nm, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic run_txn(input bit do_cpu, input bit do_fill, input logic [25:0] ca,
                         input logic [31:0] cd, input logic [3:0] cm, input logic [1:0] tm,
                         input logic [25:0] fa, input logic [31:0] fd);
    exp_t e;
    bit   stale, cdone, fdone, hit;
    int   cyc;
    stale = 1'b0;
    if (do_cpu) begin
      e = blank_exp();
      e.kind = 1; e.ts = 1'b1; e.wra = ca; e.chk_addr = 1'b1;
      exp_q.push_back(e);
      e = blank_exp();
      e.kind = 2; e.cack = 1'b1;
      hit = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (tm[w] && !hit) begin
          e.wr = 2'(1 << w);
          hit = 1'b1;
        end
      end
      if (!hit && WRALLOC && cm == 4'hF) begin
        e.wr = 2'(1 << vptr);
        vptr = (vptr + 1) % WAYS;
      end
      if (e.wr != 2'b00) begin
        e.wra = ca; e.wrd = cd; e.wrm = cm; e.chk_addr = 1'b1; e.chk_data = 1'b1;
      end
      exp_q.push_back(e);
      stale = do_fill && (fa == ca);
    end
    if (do_fill) push_fill(stale, fa, fd);

    cpuwrreq = do_cpu; cpuwra = ca; cpuwrd = cd; cpuwrm = cm; tsmatch = tm;
    fillreq = do_fill; filla = fa; filld = fd;
    cdone = !do_cpu;
    fdone = !do_fill;
    cyc = 0;
    while (!(cdone && fdone) && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (o_cpuwrack && !cdone) begin
        cdone = 1'b1;
        cpuwrreq = 1'b0;
        chk("cpu_ack_latency", cyc, 3);
      end
      if (o_fillack && !fdone) begin
        fdone = 1'b1;
        fillreq = 1'b0;
      end
    end
    if (!(cdone && fdone)) begin
      n_checks++;
      n_errs++;
      $display("FAIL txn_timeout: cpu_acked=%0b fill_acked=%0b, expected both acked within 60 cycles", cdone, fdone);
      cpuwrreq = 1'b0;
      fillreq = 1'b0;
    end
    tsmatch = 2'($urandom_range(0, 3));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected completion before 5ms");
    $fatal(1);
  end

  initial begin
    exp_t e;
    bit   found;
    logic [25:0] a;
    int   sel;

    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 1);
    chk("rst_wr", o_wr, 0);
    chk("rst_ts", o_ts, 0);
    chk("rst_clr", o_clr, 0);
    chk("rst_all", o_all, 0);
    chk("rst_cpuwrack", o_cpuwrack, 0);
    chk("rst_fillack", o_fillack, 0);
    chk("rst_wra", o_wra, 0);
    chk("rst_wrd", o_wrd, 0);
    chk("rst_wrm", o_wrm, 0);
    mon_en = 1'b1;
    push_sweep(NIDX);
    rst = 1'b0;
    count_busy(NIDX, "reset_sweep_busy");
    repeat (2) @(negedge clk);

    run_txn(1'b1, 1'b0, 26'h0000123, $urandom, 4'h3, 2'b10, '0, '0);
    run_txn(1'b1, 1'b0, 26'h0000456, $urandom, 4'hF, 2'b00, '0, '0);
    run_txn(1'b0, 1'b1, '0, '0, '0, 2'b11, 26'h100, $urandom);
    run_txn(1'b0, 1'b1, '0, '0, '0, 2'b01, 26'h200, $urandom);
    run_txn(1'b0, 1'b1, '0, '0, '0, 2'b10, 26'h300, $urandom);
    run_txn(1'b1, 1'b1, 26'h040, $urandom, 4'hF, 2'b01, 26'h040, $urandom);
    run_txn(1'b1, 1'b1, 26'h041, $urandom, 4'h5, 2'b11, 26'h042, $urandom);

    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 2);
      a = 26'h040 + 26'($urandom_range(0, 3));
      run_txn(sel != 1, sel != 0, a, $urandom,
              ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 26'h040 + 26'($urandom_range(0, 3)), $urandom);
    end

    // Flush requested while a fill is in progress: fill finishes, then a full sweep.
    push_fill(1'b0, 26'h0ABC, 32'hCAFE_F00D);
    push_sweep(NIDX);
    fillreq = 1'b1; filla = 26'h0ABC; filld = 32'hCAFE_F00D;
    @(posedge clk); #1 flushreq = 1'b1;
    @(posedge clk); #1 flushreq = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (o_fillack) found = 1'b1;
    end
    fillreq = 1'b0;
    chk("flush_during_fill_fillack_seen", found, 1);
    chk("flush_during_fill_busy_at_ack", o_busy, 0);
    count_busy(NIDX, "flush_after_fill_busy");
    repeat (2) @(negedge clk);

    // Reset in the middle of a sweep restarts it from index 0.
    push_sweep(501);
    flushreq = 1'b1;
    @(negedge clk);
    flushreq = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 1500 && !found; c++) begin
      @(negedge clk);
      if (o_all && o_wra[9:0] == 10'd500) found = 1'b1;
    end
    chk("midsweep_idx500_seen", found, 1);
    rst = 1'b1;
    vptr = 0;
    @(negedge clk);
    chk("midsweep_rst_busy", o_busy, 1);
    chk("midsweep_rst_wr", o_wr, 0);
    chk("midsweep_rst_all", o_all, 0);
    chk("midsweep_rst_wra", o_wra, 0);
    chk("midsweep_rst_queue", exp_q.size(), 0);
    push_sweep(NIDX);
    rst = 1'b0;
    count_busy(NIDX, "restart_sweep_busy");

    run_txn(1'b0, 1'b1, '0, '0, '0, 2'b00, 26'h321, $urandom);
    repeat (4) @(negedge clk);
    chk("final_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
